decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 90 +++++++++
 rtl/decode_stage_inst_decoder.sv | 167 ++++++++++++++++
 rtl/decode_stage.sv | 104 ++++++++++
 tb/tb_decode_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, funct3/funct7 encodings,
// ALU_*/BR_*/WB_* codes understood by the execute stage, and the
// decoded-instruction bundle passed from inst_decoder to decode_stage.
package decode_stage_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_SLL  = 5'd2;
   localparam logic [4:0] ALU_SLT  = 5'd3;
   localparam logic [4:0] ALU_SLTU = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_OR   = 5'd8;
   localparam logic [4:0] ALU_AND  = 5'd9;
   localparam logic [4:0] BR_BEQ   = 5'd16;
   localparam logic [4:0] BR_BNE   = 5'd17;
   localparam logic [4:0] BR_BLT   = 5'd18;
   localparam logic [4:0] BR_BGE   = 5'd19;
   localparam logic [4:0] BR_BLTU  = 5'd20;
   localparam logic [4:0] BR_BGEU  = 5'd21;
   localparam logic [4:0] ALU_X    = 5'd31;

   localparam logic [2:0] WB_ALU = 3'd0;
   localparam logic [2:0] WB_MEM = 3'd1;
   localparam logic [2:0] WB_PC  = 3'd2;
   localparam logic [2:0] WB_X   = 3'd7;

   typedef struct packed {
      logic [4:0]  alu_fn;
      logic [2:0]  wb_sel;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] store_data;
      logic [31:0] target;
      logic [4:0]  rd;
      logic        rf_wen;
      logic        mem_wen;
      logic        illegal;
   } dec_t;

   // alt selects SUB/SRA; callers only raise it where funct7=0x20 is legal
   function automatic logic [4:0] alu_fn_of(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [4:0] br_fn_of(input logic [2:0] f3);
      case (f3)
         3'd0:    return BR_BEQ;
         3'd1:    return BR_BNE;
         3'd4:    return BR_BLT;
         3'd5:    return BR_BGE;
         3'd6:    return BR_BLTU;
         3'd7:    return BR_BGEU;
         default: return ALU_X;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_inst_decoder.sv
// inst_decoder: purely combinational RV32I decoder.
// Ports:
//   inst, pc            instruction word and its address
//   rs1_data, rs2_data  register-file read data for inst[19:15] / inst[24:20]
//   dec                 control, operands, branch/jump target, rd
//   uses_rs1, uses_rs2  instruction really reads that source (feeds hazard check)
module inst_decoder
   import decode_stage_pkg::*;
(
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output dec_t        dec,
   output logic        uses_rs1,
   output logic        uses_rs2
);

   logic [6:0]  opcode;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic        writes;

   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign f3     = inst[14:12];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];
   assign f7     = inst[31:25];

   // x0 is hard-wired zero whatever the register file returns
   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rs1_data;
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rs2_data;

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'd0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   always_comb begin
      dec        = '0;
      dec.alu_fn = ALU_X;
      dec.wb_sel = WB_X;
      uses_rs1   = 1'b0;
      uses_rs2   = 1'b0;
      writes     = 1'b0;
      case (opcode)
         OP_REG: begin
            if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
               uses_rs1   = 1'b1;
               uses_rs2   = 1'b1;
               dec.alu_fn = alu_fn_of(f3, f7 == F7_ALT);
               dec.wb_sel = WB_ALU;
               dec.op1    = rs1_val;
               dec.op2    = rs2_val;
               writes     = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_IMM: begin
            // only the shift-immediates constrain funct7; ADDI etc. use it as imm
            if ((f3 == F3_SLL) ? (f7 == F7_BASE) :
                (f3 == F3_SR)  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1) begin
               uses_rs1   = 1'b1;
               dec.alu_fn = alu_fn_of(f3, (f3 == F3_SR) && (f7 == F7_ALT));
               dec.wb_sel = WB_ALU;
               dec.op1    = rs1_val;
               dec.op2    = imm_i;
               writes     = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_LUI: begin
            dec.alu_fn = ALU_ADD;
            dec.wb_sel = WB_ALU;
            dec.op2    = imm_u;
            writes     = 1'b1;
         end
         OP_AUIPC: begin
            dec.alu_fn = ALU_ADD;
            dec.wb_sel = WB_ALU;
            dec.op1    = pc;
            dec.op2    = imm_u;
            writes     = 1'b1;
         end
         OP_LOAD: begin
            if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
               uses_rs1   = 1'b1;
               dec.alu_fn = ALU_ADD;
               dec.wb_sel = WB_MEM;
               dec.op1    = rs1_val;
               dec.op2    = imm_i;
               writes     = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_STORE: begin
            if (f3 <= 3'd2) begin
               uses_rs1       = 1'b1;
               uses_rs2       = 1'b1;
               dec.alu_fn     = ALU_ADD;
               dec.op1        = rs1_val;
               dec.op2        = imm_s;
               dec.store_data = rs2_val;
               dec.mem_wen    = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_BRANCH: begin
            if (f3 != 3'd2 && f3 != 3'd3) begin
               uses_rs1   = 1'b1;
               uses_rs2   = 1'b1;
               dec.alu_fn = br_fn_of(f3);
               dec.op1    = rs1_val;
               dec.op2    = rs2_val;
               dec.target = pc + imm_b;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_JAL: begin
            // ALU forms the link address pc+4; target carries the jump
            dec.alu_fn = ALU_ADD;
            dec.wb_sel = WB_PC;
            dec.op1    = pc;
            dec.op2    = 32'd4;
            dec.target = pc + imm_j;
            writes     = 1'b1;
         end
         OP_JALR: begin
            if (f3 == 3'd0) begin
               uses_rs1   = 1'b1;
               dec.alu_fn = ALU_ADD;
               dec.wb_sel = WB_PC;
               dec.op1    = rs1_val;
               dec.op2    = imm_i;
               writes     = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         default: dec.illegal = 1'b1;
      endcase

      if (dec.alu_fn == ALU_SLL || dec.alu_fn == ALU_SRL || dec.alu_fn == ALU_SRA)
         dec.op2 = {27'd0, dec.op2[4:0]};

      dec.rd     = writes ? rd : 5'd0;
      dec.rf_wen = writes && (rd != 5'd0);
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with load-use hazard detection and the
// ID/EX pipeline register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_valid, if_inst, if_pc        instruction from fetch
//   id_ready                        instruction accepted this cycle
//   rf_rs1_addr/_data, rf_rs2_*     register-file read port (same cycle)
//   ex_ready, flush                 execute backpressure / taken-branch kill
//   ex_*                            registered decoded instruction to execute
module decode_stage
   import decode_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   input  logic [31:0] if_inst,
   input  logic [31:0] if_pc,
   output logic        id_ready,
   output logic [4:0]  rf_rs1_addr,
   output logic [4:0]  rf_rs2_addr,
   input  logic [31:0] rf_rs1_data,
   input  logic [31:0] rf_rs2_data,
   input  logic        ex_ready,
   input  logic        flush,
   output logic        ex_valid,
   output logic [4:0]  ex_alu_fn,
   output logic [2:0]  ex_wb_sel,
   output logic [31:0] ex_op1,
   output logic [31:0] ex_op2,
   output logic [31:0] ex_store_data,
   output logic [31:0] ex_target,
   output logic [31:0] ex_pc,
   output logic [4:0]  ex_rd,
   output logic        ex_rf_wen,
   output logic        ex_mem_wen,
   output logic        ex_illegal
);

   dec_t dec;
   logic uses_rs1;
   logic uses_rs2;
   logic hazard;

   assign rf_rs1_addr = if_inst[19:15];
   assign rf_rs2_addr = if_inst[24:20];

   inst_decoder u_inst_decoder (
      .inst     (if_inst),
      .pc       (if_pc),
      .rs1_data (rf_rs1_data),
      .rs2_data (rf_rs2_data),
      .dec      (dec),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2)
   );

   // load result not available until after execute: stall a consumer one cycle
   assign hazard = ex_valid && (ex_wb_sel == WB_MEM) && (ex_rd != 5'd0) &&
                   ((uses_rs1 && ex_rd == rf_rs1_addr) ||
                    (uses_rs2 && ex_rd == rf_rs2_addr));

   assign id_ready = ex_ready && !hazard && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid      <= 1'b0;
         ex_alu_fn     <= ALU_X;
         ex_wb_sel     <= WB_X;
         ex_op1        <= '0;
         ex_op2        <= '0;
         ex_store_data <= '0;
         ex_target     <= '0;
         ex_pc         <= '0;
         ex_rd         <= '0;
         ex_rf_wen     <= 1'b0;
         ex_mem_wen    <= 1'b0;
         ex_illegal    <= 1'b0;
      end else if (flush) begin
         ex_valid   <= 1'b0;
         ex_rf_wen  <= 1'b0;
         ex_mem_wen <= 1'b0;
      end else if (ex_ready) begin
         if (hazard) begin
            ex_valid   <= 1'b0;
            ex_rf_wen  <= 1'b0;
            ex_mem_wen <= 1'b0;
         end else begin
            ex_valid      <= if_valid;
            ex_alu_fn     <= dec.alu_fn;
            ex_wb_sel     <= dec.wb_sel;
            ex_op1        <= dec.op1;
            ex_op2        <= dec.op2;
            ex_store_data <= dec.store_data;
            ex_target     <= dec.target;
            ex_pc         <= if_pc;
            ex_rd         <= dec.rd;
            ex_rf_wen     <= if_valid && dec.rf_wen;
            ex_mem_wen    <= if_valid && dec.mem_wen;
            ex_illegal    <= if_valid && dec.illegal;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
   import decode_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        id_ready;
   logic [4:0]  rf_rs1_addr;
   logic [4:0]  rf_rs2_addr;
   logic [31:0] rf_rs1_data;
   logic [31:0] rf_rs2_data;
   logic        ex_ready;
   logic        flush;
   logic        ex_valid;
   logic [4:0]  ex_alu_fn;
   logic [2:0]  ex_wb_sel;
   logic [31:0] ex_op1;
   logic [31:0] ex_op2;
   logic [31:0] ex_store_data;
   logic [31:0] ex_target;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_rf_wen;
   logic        ex_mem_wen;
   logic        ex_illegal;

   always #5 clk = ~clk;

   logic [31:0] regs [32];
   assign rf_rs1_data = regs[rf_rs1_addr];
   assign rf_rs2_data = regs[rf_rs2_addr];

   decode_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_valid      (if_valid),
      .if_inst       (if_inst),
      .if_pc         (if_pc),
      .id_ready      (id_ready),
      .rf_rs1_addr   (rf_rs1_addr),
      .rf_rs2_addr   (rf_rs2_addr),
      .rf_rs1_data   (rf_rs1_data),
      .rf_rs2_data   (rf_rs2_data),
      .ex_ready      (ex_ready),
      .flush         (flush),
      .ex_valid      (ex_valid),
      .ex_alu_fn     (ex_alu_fn),
      .ex_wb_sel     (ex_wb_sel),
      .ex_op1        (ex_op1),
      .ex_op2        (ex_op2),
      .ex_store_data (ex_store_data),
      .ex_target     (ex_target),
      .ex_pc         (ex_pc),
      .ex_rd         (ex_rd),
      .ex_rf_wen     (ex_rf_wen),
      .ex_mem_wen    (ex_mem_wen),
      .ex_illegal    (ex_illegal)
   );

   typedef struct {
      logic [4:0]  fn;
      logic [2:0]  wb;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] sd;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        rfw;
      logic        memw;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic exp_v  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [4:0] fn, input logic [2:0] wb,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] sd, input logic [31:0] tgt,
                               input logic [31:0] pc, input logic [4:0] rd,
                               input logic rfw, input logic memw, input logic ill);
      exp_t e;
      e.fn = fn; e.wb = wb; e.op1 = op1; e.op2 = op2; e.sd = sd; e.tgt = tgt;
      e.pc = pc; e.rd = rd; e.rfw = rfw; e.memw = memw; e.ill = ill;
      return e;
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OP_REG};
   endfunction

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
   endfunction

   function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm[31:12], rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
   endfunction

   // One clock: drive inputs at negedge, check the ex_* register against the
   // scoreboard head, check id_ready, then advance the bench's own ex_valid model.
   task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic exp_rdy, input exp_t e);
      exp_t h;
      logic nv;
      @(negedge clk);
      if_valid = v; if_inst = inst; if_pc = pc; ex_ready = rdy; flush = fl;
      #1;
      chk("ex_valid", ex_valid, exp_v);
      if (exp_v && sb.size() > 0) begin
         h = sb[0];
         chk("alu_fn", ex_alu_fn, h.fn);
         chk("wb_sel", ex_wb_sel, h.wb);
         chk("op1", ex_op1, h.op1);
         chk("op2", ex_op2, h.op2);
         chk("store_data", ex_store_data, h.sd);
         chk("target", ex_target, h.tgt);
         chk("pc", ex_pc, h.pc);
         chk("rd", ex_rd, h.rd);
         chk("rf_wen", ex_rf_wen, h.rfw);
         chk("mem_wen", ex_mem_wen, h.memw);
         chk("illegal", ex_illegal, h.ill);
      end else if (!exp_v) begin
         chk("rf_wen_idle", ex_rf_wen, 1'b0);
         chk("mem_wen_idle", ex_mem_wen, 1'b0);
      end
      chk("id_ready", id_ready, exp_rdy);
      nv = fl ? 1'b0 : (!rdy ? exp_v : (exp_rdy && v));
      if (exp_v && (rdy || fl) && sb.size() > 0) void'(sb.pop_front());
      if (!fl && rdy && exp_rdy && v) sb.push_back(e);
      exp_v = nv;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_valid"}, ex_valid, 1'b0);
      chk({tag, "_alu_fn"}, ex_alu_fn, ALU_X);
      chk({tag, "_wb_sel"}, ex_wb_sel, WB_X);
      chk({tag, "_op1"}, ex_op1, 32'd0);
      chk({tag, "_op2"}, ex_op2, 32'd0);
      chk({tag, "_store_data"}, ex_store_data, 32'd0);
      chk({tag, "_target"}, ex_target, 32'd0);
      chk({tag, "_pc"}, ex_pc, 32'd0);
      chk({tag, "_rd"}, ex_rd, 5'd0);
      chk({tag, "_rf_wen"}, ex_rf_wen, 1'b0);
      chk({tag, "_mem_wen"}, ex_mem_wen, 1'b0);
      chk({tag, "_illegal"}, ex_illegal, 1'b0);
   endtask

   exp_t nil;
   logic [31:0] i_lw;
   logic [31:0] i_use;

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 + i;
      regs[0] = 32'hDEAD_BEEF;   // x0 must read as zero regardless
      regs[2] = 32'd5;
      regs[3] = 32'h23;
      regs[4] = 32'h100;
      regs[6] = 32'd7;
      regs[7] = 32'h8000_0000;
      nil = mk(ALU_X, WB_X, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      rst_n = 1'b0; if_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0;
      ex_ready = 1'b1; flush = 1'b0;
      #12;
      check_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // arithmetic / immediates / shifts / x0
      cyc(1, enc_i(-1, 2, F3_ADD, 1, OP_IMM), 32'h1000, 1, 0, 1,
          mk(ALU_ADD, WB_ALU, 5, 32'hFFFF_FFFF, 0, 0, 32'h1000, 1, 1, 0, 0));
      cyc(1, enc_r(F7_BASE, 3, 2, F3_SLL, 1), 32'h1004, 1, 0, 1,
          mk(ALU_SLL, WB_ALU, 5, 3, 0, 0, 32'h1004, 1, 1, 0, 0));
      cyc(1, enc_i(32'h404, 7, F3_SR, 8, OP_IMM), 32'h1008, 1, 0, 1,
          mk(ALU_SRA, WB_ALU, 32'h8000_0000, 4, 0, 0, 32'h1008, 8, 1, 0, 0));
      cyc(1, enc_r(F7_ALT, 2, 6, F3_ADD, 9), 32'h100C, 1, 0, 1,
          mk(ALU_SUB, WB_ALU, 7, 5, 0, 0, 32'h100C, 9, 1, 0, 0));
      cyc(1, enc_u(32'h1234_5000, 10, OP_LUI), 32'h1010, 1, 0, 1,
          mk(ALU_ADD, WB_ALU, 0, 32'h1234_5000, 0, 0, 32'h1010, 10, 1, 0, 0));
      cyc(1, enc_u(32'hFFFF_F000, 11, OP_AUIPC), 32'h1014, 1, 0, 1,
          mk(ALU_ADD, WB_ALU, 32'h1014, 32'hFFFF_F000, 0, 0, 32'h1014, 11, 1, 0, 0));
      cyc(1, enc_s(-4, 6, 4, 3'd2), 32'h1018, 1, 0, 1,
          mk(ALU_ADD, WB_X, 32'h100, 32'hFFFF_FFFC, 7, 0, 32'h1018, 0, 0, 1, 0));

      // beq held by ex_ready=0 for three cycles, then jal captured on release
      cyc(1, enc_b(-8, 6, 2, 3'd0), 32'h101C, 1, 0, 1,
          mk(BR_BEQ, WB_X, 5, 7, 0, 32'h1014, 32'h101C, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++)
         cyc(1, enc_j(-16, 1), 32'h1020, 0, 0, 0, nil);
      cyc(1, enc_j(-16, 1), 32'h1020, 1, 0, 1,
          mk(ALU_ADD, WB_PC, 32'h1020, 4, 0, 32'h1010, 32'h1020, 1, 1, 0, 0));
      cyc(1, enc_i(8, 4, 3'd0, 1, OP_JALR), 32'h1024, 1, 0, 1,
          mk(ALU_ADD, WB_PC, 32'h100, 8, 0, 0, 32'h1024, 1, 1, 0, 0));
      cyc(1, enc_r(F7_BASE, 2, 0, F3_ADD, 5), 32'h1028, 1, 0, 1,
          mk(ALU_ADD, WB_ALU, 0, 5, 0, 0, 32'h1028, 5, 1, 0, 0));
      cyc(1, enc_i(1, 2, F3_ADD, 0, OP_IMM), 32'h102C, 1, 0, 1,
          mk(ALU_ADD, WB_ALU, 5, 1, 0, 0, 32'h102C, 0, 0, 0, 0));

      // load-use: one stall, one bubble, consumer issued the cycle after
      i_lw  = enc_i(0, 4, 3'd2, 3, OP_LOAD);
      i_use = enc_r(F7_BASE, 6, 3, F3_ADD, 5);
      cyc(1, i_lw, 32'h1030, 1, 0, 1,
          mk(ALU_ADD, WB_MEM, 32'h100, 0, 0, 0, 32'h1030, 3, 1, 0, 0));
      cyc(1, i_use, 32'h1034, 1, 0, 0, nil);
      cyc(1, i_use, 32'h1034, 1, 0, 1,
          mk(ALU_ADD, WB_ALU, 32'h23, 7, 0, 0, 32'h1034, 5, 1, 0, 0));

      // LUI whose immediate bits alias rs1=x3 does not read x3: no stall
      cyc(1, i_lw, 32'h1038, 1, 0, 1,
          mk(ALU_ADD, WB_MEM, 32'h100, 0, 0, 0, 32'h1038, 3, 1, 0, 0));
      cyc(1, enc_u(32'h0001_8000, 12, OP_LUI), 32'h103C, 1, 0, 1,
          mk(ALU_ADD, WB_ALU, 0, 32'h0001_8000, 0, 0, 32'h103C, 12, 1, 0, 0));

      // flush together with hazard, then the refetched consumer
      cyc(1, i_lw, 32'h1040, 1, 0, 1,
          mk(ALU_ADD, WB_MEM, 32'h100, 0, 0, 0, 32'h1040, 3, 1, 0, 0));
      cyc(1, i_use, 32'h1044, 1, 1, 0, nil);
      cyc(1, i_use, 32'h2000, 1, 0, 1,
          mk(ALU_ADD, WB_ALU, 32'h23, 7, 0, 0, 32'h2000, 5, 1, 0, 0));

      // illegal word
      cyc(1, 32'hFFFF_FFFF, 32'h2004, 1, 0, 1,
          mk(ALU_X, WB_X, 0, 0, 0, 0, 32'h2004, 0, 0, 0, 1));
      cyc(0, 32'd0, 32'd0, 1, 0, 1, nil);

      // reset asserted while an instruction is held
      cyc(1, enc_i(-1, 2, F3_ADD, 1, OP_IMM), 32'h3000, 1, 0, 1,
          mk(ALU_ADD, WB_ALU, 5, 32'hFFFF_FFFF, 0, 0, 32'h3000, 1, 1, 0, 0));
      cyc(0, 32'd0, 32'd0, 0, 0, 0, nil);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("rst_stall");
      sb.delete();
      exp_v = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, enc_i(3, 6, F3_ADD, 13, OP_IMM), 32'h3004, 1, 0, 1,
          mk(ALU_ADD, WB_ALU, 7, 3, 0, 0, 32'h3004, 13, 1, 0, 0));
      cyc(0, 32'd0, 32'd0, 1, 0, 1, nil);
      cyc(0, 32'd0, 32'd0, 1, 0, 1, nil);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
